// File: rtl/mpu_matrix_loader_pkg.sv
// mpu_matrix_loader_pkg
//   Shared definitions for the MPU matrix loader slice.
//   - Element width and matrix geometry (ELEM_W, DIM, ELEMS, MAT_W).
//   - Index and position widths.
//   - Loader state encoding.
//   - The at(col,row) helper, which maps a matrix coordinate to a flat element index.
package mpu_matrix_loader_pkg;

  localparam int ELEM_W = 8;
  localparam int DIM    = 5;
  localparam int ELEMS  = DIM * DIM;
  localparam int MAT_W  = ELEM_W * ELEMS;
  localparam int IDX_W  = 5;
  localparam int POS_W  = 3;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } loader_state_t;

  // Column-major flattening: element k = row + DIM*col
  function automatic logic [IDX_W-1:0] at(input logic [POS_W-1:0] col,
                                          input logic [POS_W-1:0] row);
    return IDX_W'(row) + IDX_W'(col) * IDX_W'(DIM);
  endfunction

endpackage

// File: rtl/mpu_index_counter.sv
// mpu_index_counter
//   Mod-ELEMS element counter used by the matrix loader.
//   Ports:
//     clk, rst   clock and synchronous active-high reset
//     inc        advance the index by one (wraps at ELEMS-1)
//     clr        force the index back to 0 (wins over inc)
//     idx        current index, 0..ELEMS-1
//     wrap       high when inc is applied at the last index
//     col, row   idx / DIM and idx % DIM, for debug and addressing
module mpu_index_counter
  import mpu_matrix_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [IDX_W-1:0] idx,
  output logic             wrap,
  output logic [POS_W-1:0] col,
  output logic [POS_W-1:0] row
);

  assign wrap = inc && (idx == IDX_W'(ELEMS - 1));
  assign col  = POS_W'(idx / IDX_W'(DIM));
  assign row  = POS_W'(idx % IDX_W'(DIM));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= wrap ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/mpu_matrix_loader.sv
// mpu_matrix_loader
//   Collects signed 8-bit elements from a valid/ready stream into a flat 5x5 matrix.
//   Element k = row + 5*col lives at matrix_out[8k +: 8].
//   The matrix is then presented to the downstream operator with a valid/ready handshake.
//   Ports:
//     clk, rst      clock and synchronous active-high reset
//     in_data       next element, in index order 0..24
//     in_valid      in_data is valid
//     in_ready      loader accepts an element this cycle (registered)
//     flush         end the fill early and zero the rest (MPU_LOADER_ZEROPAD_EN only)
//     elem_idx      index of the next element to be written
//     matrix_out    assembled matrix; frozen while matrix_valid is high
//     matrix_valid  matrix_out is complete
//     matrix_ready  consumer takes the matrix this cycle
//   Configuration macro: MPU_LOADER_ZEROPAD_EN enables the flush port and the zero-pad behaviour.
module mpu_matrix_loader
  import mpu_matrix_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
`ifdef MPU_LOADER_ZEROPAD_EN
  input  logic              flush,
`endif
  output logic [IDX_W-1:0]  elem_idx,
  output logic [0:MAT_W-1]  matrix_out,
  output logic              matrix_valid,
  input  logic              matrix_ready
);

  loader_state_t    state;
  logic             accept;
  logic             flush_fire;
  logic             last_accept;
  logic [POS_W-1:0] col;
  logic [POS_W-1:0] row;
  logic [IDX_W-1:0] wr_idx;

  // in_ready is a registered copy of (state == FILL), so accept has no path from matrix_ready
  assign accept = in_valid && in_ready;

`ifdef MPU_LOADER_ZEROPAD_EN
  assign flush_fire = flush && (state == FILL);
`else
  assign flush_fire = 1'b0;
`endif

  mpu_index_counter u_index_counter (
    .clk  (clk),
    .rst  (rst),
    .inc  (accept),
    .clr  (flush_fire),
    .idx  (elem_idx),
    .wrap (last_accept),
    .col  (col),
    .row  (row)
  );

  assign wr_idx = at(col, row);

`ifdef MPU_LOADER_ZEROPAD_EN
  int wr_pos;
  assign wr_pos = int'(wr_idx);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILL;
      in_ready     <= 1'b1;
      matrix_valid <= 1'b0;
      matrix_out   <= '0;
    end else begin
      if (accept) begin
        matrix_out[ELEM_W*wr_idx +: ELEM_W] <= in_data;
      end
`ifdef MPU_LOADER_ZEROPAD_EN
      // Zero everything after the write slot; the slot itself is zeroed only if no byte lands there
      if (flush_fire) begin
        for (int k = 0; k < ELEMS; k++) begin
          if ((k > wr_pos) || ((k == wr_pos) && !accept)) begin
            matrix_out[k*ELEM_W +: ELEM_W] <= '0;
          end
        end
      end
`endif
      case (state)
        FILL: begin
          if (last_accept || flush_fire) begin
            state        <= FULL;
            in_ready     <= 1'b0;
            matrix_valid <= 1'b1;
          end
        end
        FULL: begin
          // Contents are kept; the next fill overwrites them element by element
          if (matrix_ready) begin
            state        <= FILL;
            in_ready     <= 1'b1;
            matrix_valid <= 1'b0;
          end
        end
        default: begin
          state        <= FILL;
          in_ready     <= 1'b1;
          matrix_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// tb_mpu_matrix_loader
//   Directed bench for mpu_matrix_loader.
//   Complete matrices are pushed to a scoreboard queue as they are streamed in.
//   They are popped and compared when matrix_valid appears.
//   Build with MPU_LOADER_ZEROPAD_EN defined to exercise the flush path as well.
module tb_mpu_matrix_loader;

  localparam int EW = 8;
  localparam int NE = 25;
  localparam int MW = EW * NE;

  logic          clk = 1'b0;
  logic          rst;
  logic [EW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic [4:0]    elem_idx;
  logic [0:MW-1] matrix_out;
  logic          matrix_valid;
  logic          matrix_ready;

  int checks = 0;
  int errors = 0;

  logic [0:MW-1] model;
  logic [0:MW-1] expected;
  logic [0:MW-1] exp_q[$];

  mpu_matrix_loader dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
`ifdef MPU_LOADER_ZEROPAD_EN
    .flush        (flush),
`endif
    .elem_idx     (elem_idx),
    .matrix_out   (matrix_out),
    .matrix_valid (matrix_valid),
    .matrix_ready (matrix_ready)
  );

  always #5 clk = ~clk;

  // First-fill stream: 2, -1, 0, 4, ..., 1
  function automatic logic [EW-1:0] fillVal(input int k);
    case (k)
      0:       return 8'd2;
      1:       return 8'hFF;
      2:       return 8'd0;
      3:       return 8'd4;
      24:      return 8'd1;
      default: return EW'(k * 7 - 50);
    endcase
  endfunction

  // Inputs change on the falling edge; outputs are sampled there too
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [EW-1:0] d, input logic mr);
    in_valid     = v;
    in_data      = d;
    matrix_ready = mr;
    step();
  endtask

  task automatic checkOutput(input string tag, input logic [0:MW-1] observed,
                             input logic [0:MW-1] required);
    checks++;
    assert (observed === required)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, required);
    end
  endtask

  task automatic waitValid(input int budget);
    for (int i = 0; i < budget && matrix_valid !== 1'b1; i++) step();
    checkOutput("matrix_valid_timeout", MW'(matrix_valid), MW'(1));
  endtask

  task automatic popCompare(input string tag);
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, MW'(exp_q.size()), MW'(1));
    end else begin
      expected = exp_q.pop_front();
      checkOutput(tag, matrix_out, expected);
    end
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    matrix_ready = 1'b0;
    flush        = 1'b0;
    model        = '0;

    // Reset for two cycles
    @(negedge clk);
    step();
    checkOutput("reset_matrix_out", matrix_out, '0);
    checkOutput("reset_matrix_valid", MW'(matrix_valid), MW'(0));
    checkOutput("reset_elem_idx", MW'(elem_idx), MW'(0));
    rst = 1'b0;
    step();
    checkOutput("reset_in_ready", MW'(in_ready), MW'(1));

    // Full 25-element fill with in_valid held high
    for (int k = 0; k < NE; k++) begin
      if (k == 12) checkOutput("fill_elem_idx_12", MW'(elem_idx), MW'(12));
      model[k*EW +: EW] = fillVal(k);
      applyStimulus(1'b1, fillVal(k), 1'b0);
    end
    exp_q.push_back(model);
    in_valid = 1'b0;
    checkOutput("fill_valid_cycle26", MW'(matrix_valid), MW'(1));
    waitValid(4);
    popCompare("fill_matrix");
    checkOutput("fill_elem0", MW'(matrix_out[0 +: EW]), MW'(8'd2));
    checkOutput("fill_elem1", MW'(matrix_out[EW +: EW]), MW'(8'hFF));
    checkOutput("fill_elem24", MW'(matrix_out[24*EW +: EW]), MW'(8'd1));
    checkOutput("fill_elem_idx_wrap", MW'(elem_idx), MW'(0));

    // Backpressure: consumer stalls, input pulses must be ignored
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i[0], 8'h55, 1'b0);
      checkOutput("bp_matrix_out", matrix_out, model);
      checkOutput("bp_in_ready", MW'(in_ready), MW'(0));
    end
    checkOutput("bp_elem_idx", MW'(elem_idx), MW'(0));

    // Handoff: byte offered together with matrix_ready is not taken
    applyStimulus(1'b1, 8'd7, 1'b1);
    checkOutput("handoff_valid_low", MW'(matrix_valid), MW'(0));
    checkOutput("handoff_in_ready", MW'(in_ready), MW'(1));
    checkOutput("handoff_elem0_kept", MW'(matrix_out[0 +: EW]), MW'(8'd2));
    checkOutput("handoff_elem_idx0", MW'(elem_idx), MW'(0));
    applyStimulus(1'b1, 8'd7, 1'b0);
    model[0 +: EW] = 8'd7;
    checkOutput("handoff_elem0_written", MW'(matrix_out[0 +: EW]), MW'(8'd7));
    checkOutput("handoff_elem_idx1", MW'(elem_idx), MW'(1));

    // Mid-fill reset after 12 accepts in total
    for (int k = 1; k < 12; k++) applyStimulus(1'b1, 8'(k + 40), 1'b0);
    checkOutput("midfill_elem_idx12", MW'(elem_idx), MW'(12));
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst = 1'b0;
    model = '0;
    checkOutput("midfill_reset_idx", MW'(elem_idx), MW'(0));
    checkOutput("midfill_reset_matrix", matrix_out, '0);
    checkOutput("midfill_reset_valid", MW'(matrix_valid), MW'(0));

    // Refill with a fresh pattern, including negative values
    for (int k = 0; k < NE; k++) begin
      model[k*EW +: EW] = 8'(100 + 9 * k);
      applyStimulus(1'b1, 8'(100 + 9 * k), 1'b0);
    end
    exp_q.push_back(model);
    in_valid = 1'b0;
    waitValid(4);
    popCompare("refill_matrix");
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("refill_release_valid", MW'(matrix_valid), MW'(0));
    matrix_ready = 1'b0;

`ifdef MPU_LOADER_ZEROPAD_EN
    // Early flush with a byte in the same cycle
    for (int k = 0; k < 3; k++) begin
      model[k*EW +: EW] = 8'(5 + k);
      applyStimulus(1'b1, 8'(5 + k), 1'b0);
    end
    model[3*EW +: EW] = 8'd8;
    for (int k = 4; k < NE; k++) model[k*EW +: EW] = '0;
    exp_q.push_back(model);
    flush = 1'b1;
    applyStimulus(1'b1, 8'd8, 1'b0);
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_valid_next", MW'(matrix_valid), MW'(1));
    popCompare("flush_matrix");
    checkOutput("flush_elem_idx", MW'(elem_idx), MW'(0));

    // Flush is ignored while FULL
    flush = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b0);
    checkOutput("flush_full_ignored", matrix_out, model);
    flush = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b1);
    matrix_ready = 1'b0;

    // Flush at index 0 with no data gives an all-zero matrix
    exp_q.push_back('0);
    flush = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b0);
    flush = 1'b0;
    checkOutput("flush_empty_valid", MW'(matrix_valid), MW'(1));
    popCompare("flush_empty_matrix");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
